// File: rtl/fwd_tag_tracker.sv
// Purpose : tracks EX/MM destination tags and produces rs1/rs2 bypass selects plus load-use stall.
// Latency : selects, tags and stall are combinational (zero cycle); stage state advances on clk.
// Backpr. : pipe_hold freezes all state; load_use_stall holds IF/ID and bubbles EX.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   pipe_hold, flush                 global freeze; kill of the ID instruction
//   id_valid/rs1/rs2/rd/wr_en/is_load  decoded ID instruction
//   ex_pro_rs, mm_pro_rs, mm_mem_rs  producer tags (0 when none)
//   rs1_sel, rs2_sel                 00 regfile, 01 EX ALU, 10 MM ALU, 11 MM load
//   load_use_stall, stall_cnt        hazard stall and saturating stall-cycle count
module fwd_tag_tracker #(
    parameter int REG_NUM   = 32,
    parameter int CNT_WIDTH = 16,
    localparam int TW       = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [TW-1:0]        id_rs1,
    input  logic [TW-1:0]        id_rs2,
    input  logic [TW-1:0]        id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    output logic [TW-1:0]        ex_pro_rs,
    output logic [TW-1:0]        mm_pro_rs,
    output logic [TW-1:0]        mm_mem_rs,
    output logic [1:0]           rs1_sel,
    output logic [1:0]           rs2_sel,
    output logic                 load_use_stall,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MMA = 2'b10;
    localparam logic [1:0] SEL_MML = 2'b11;

    logic          ex_v, ex_ld, mm_v, mm_ld;
    logic [TW-1:0] ex_rd, mm_rd;

    logic          rs1_haz, rs2_haz;
    logic          ex_load_en;

    // Tags are exposed only when the entry is valid, so an invalid entry's
    // stale rd can never be mistaken for a producer downstream.
    assign ex_pro_rs = (ex_v && !ex_ld) ? ex_rd : '0;
    assign mm_pro_rs = (mm_v && !mm_ld) ? mm_rd : '0;
    assign mm_mem_rs = (mm_v &&  mm_ld) ? mm_rd : '0;

    // EX is checked first: it holds the younger write to the same register.
    // A load in EX has no data yet, so the operand falls back to the regfile
    // select while the stall keeps the consumer in ID.
    function automatic logic [1:0] calc_sel(input logic [TW-1:0] rs);
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs == '0 || !id_valid)
            sel = SEL_RF;
        else if (ex_v && ex_rd == rs)
            sel = ex_ld ? SEL_RF : SEL_EX;
        else if (mm_v && mm_rd == rs)
            sel = mm_ld ? SEL_MML : SEL_MMA;
        return sel;
    endfunction

    assign rs1_sel = calc_sel(id_rs1);
    assign rs2_sel = calc_sel(id_rs2);

    assign rs1_haz = ex_v && ex_ld && (id_rs1 != '0) && (ex_rd == id_rs1);
    assign rs2_haz = ex_v && ex_ld && (id_rs2 != '0) && (ex_rd == id_rs2);

    // Not gated by pipe_hold: the stall must stay visible while frozen so
    // IF/ID keep holding once the freeze lifts.
    assign load_use_stall = id_valid && !flush && (rs1_haz || rs2_haz);

    // x0 writers and non-writers never occupy a tracker entry.
    assign ex_load_en = id_valid && id_wr_en && (id_rd != '0) && !flush && !load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v      <= 1'b0;
            ex_rd     <= '0;
            ex_ld     <= 1'b0;
            mm_v      <= 1'b0;
            mm_rd     <= '0;
            mm_ld     <= 1'b0;
            stall_cnt <= '0;
        end else if (!pipe_hold) begin
            // The EX entry is older than the flushed ID instruction, so it
            // always advances into MM regardless of flush.
            mm_v  <= ex_v;
            mm_rd <= ex_rd;
            mm_ld <= ex_ld;
            ex_v  <= ex_load_en;
            ex_rd <= ex_load_en ? id_rd : '0;
            ex_ld <= ex_load_en ? id_is_load : 1'b0;
            if (load_use_stall && stall_cnt != {CNT_WIDTH{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_tag_tracker.sv
// Purpose : scoreboard bench for fwd_tag_tracker; stimulus queues expected outputs, monitor compares.
// Latency : one expectation per driven cycle, checked on the following falling edge.
// Backpr. : none; pipe_hold and flush are driven as ordinary stimulus.
module tb_fwd_tag_tracker;

    localparam int CW = 6;   // small counter so saturation is reachable quickly
    localparam int TW = 5;
    localparam int VW = 3*TW + 2 + 2 + 1 + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_hold = 1'b0, flush = 1'b0;
    logic          id_valid = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
    logic [TW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [TW-1:0] ex_pro_rs, mm_pro_rs, mm_mem_rs;
    logic [1:0]    rs1_sel, rs2_sel;
    logic          load_use_stall;
    logic [CW-1:0] stall_cnt;

    fwd_tag_tracker #(.REG_NUM(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .ex_pro_rs(ex_pro_rs), .mm_pro_rs(mm_pro_rs), .mm_mem_rs(mm_mem_rs),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [VW-1:0] pk(input logic [TW-1:0] ex, mp, mm,
                                         input logic [1:0] s1, s2,
                                         input logic st, input logic [CW-1:0] c);
        return {ex, mp, mm, s1, s2, st, c};
    endfunction

    // Monitor: one expectation per falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {ex_pro_rs, mm_pro_rs, mm_mem_rs, rs1_sel, rs2_sel, load_use_stall, stall_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got ex=%0d mmp=%0d mmm=%0d s1=%b s2=%b st=%b cnt=%0d, want ex=%0d mmp=%0d mmm=%0d s1=%b s2=%b st=%b cnt=%0d",
                         nm, a[VW-1 -: TW], a[VW-1-TW -: TW], a[VW-1-2*TW -: TW],
                         a[CW+4 +: 2], a[CW+2 +: 2], a[CW], a[CW-1:0],
                         e[VW-1 -: TW], e[VW-1-TW -: TW], e[VW-1-2*TW -: TW],
                         e[CW+4 +: 2], e[CW+2 +: 2], e[CW], e[CW-1:0]);
            end
        end
    end

    task automatic step(input string nm, input logic v, input logic [TW-1:0] r1, r2, rd,
                        input logic wr, ld, fl, hd, input logic [VW-1:0] e);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_wr_en = wr; id_is_load = ld; flush = fl; pipe_hold = hd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        logic [CW-1:0] c;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        //    name          v  rs1 rs2 rd wr ld fl hd   ex mmp mmm s1 s2 st cnt
        step("reset",       0, 0,  0,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        // ALU forward from EX then from MM
        step("t1_add",      1, 0,  0,  5, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        step("t1_ex_fwd",   1, 5,  0,  0, 0, 0, 0, 0, pk(5, 0, 0, 1, 0, 0, 0));
        step("t1_mm_fwd",   1, 5,  6,  0, 0, 0, 0, 0, pk(0, 5, 0, 2, 0, 0, 0));
        // load-use hazard then load-data forward
        step("t2_load",     1, 0,  0,  7, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        step("t2_stall",    1, 1,  7,  8, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0));
        step("t2_mm_load",  1, 1,  7,  8, 1, 0, 0, 0, pk(0, 0, 7, 0, 3, 0, 1));
        // EX beats MM on the same register
        step("t3_w1",       1, 0,  0,  3, 1, 0, 0, 0, pk(8, 0, 0, 0, 0, 0, 1));
        step("t3_w2",       1, 0,  0,  3, 1, 0, 0, 0, pk(3, 8, 0, 0, 0, 0, 1));
        step("t3_prio",     1, 3,  3,  0, 0, 0, 0, 0, pk(3, 3, 0, 1, 1, 0, 1));
        // x0 writers never tracked, x0 never forwarded
        step("t4_x0_wr",    1, 0,  0,  0, 1, 0, 0, 0, pk(0, 3, 0, 0, 0, 0, 1));
        step("t4_x0_ld",    1, 0,  0,  0, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
        step("t4_x0_use",   1, 0,  0,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
        // flush suppresses the stall and keeps EX empty
        step("t5_load",     1, 0,  0,  7, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
        step("t5_flush",    1, 7,  0,  9, 1, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 1));
        step("t5_ex_inv",   1, 7,  0,  0, 0, 0, 0, 0, pk(0, 0, 7, 3, 0, 0, 1));
        // pipe_hold freezes state and counter with a pending stall
        step("t5_load2",    1, 0,  0,  7, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
        step("t5_hold0",    1, 7,  0,  0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 1));
        step("t5_hold1",    1, 7,  0,  0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 1));
        step("t5_hold2",    1, 7,  0,  0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 1));
        step("t5_release",  1, 7,  0,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 1));
        step("t5_after",    1, 7,  0,  0, 0, 0, 0, 0, pk(0, 0, 7, 3, 0, 0, 2));

        // Saturation: load/consumer pairs give one stall every other cycle.
        c = 2;
        for (int k = 0; k < (1 << CW) + 2; k++) begin
            step("t6_load",  1, 0, 0, 7, 1, 1, 0, 0, pk(0, 0, (k == 0) ? 5'd0 : 5'd7, 0, 0, 0, c));
            step("t6_stall", 1, 7, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, c));
            if (c != {CW{1'b1}}) c = c + 1'b1;
        end
        step("t6_sat",      1, 0,  0,  0, 0, 0, 0, 0, pk(0, 0, 7, 0, 0, 0, {CW{1'b1}}));

        // Async reset mid-cycle: MM load and rs1 forward would be visible without it.
        step("t6_pre",      1, 0,  0,  7, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, {CW{1'b1}}));
        step("t6_pre2",     1, 0,  0,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, {CW{1'b1}}));
        @(posedge clk);
        #1;
        id_valid = 1; id_rs1 = 7; id_rs2 = 0; id_rd = 0; id_wr_en = 0; id_is_load = 0;
        #1 rst_n = 1'b0;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
        name_q.push_back("t6_async_rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        step("t6_post",     1, 7,  0,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
